// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : cache_ctrl_pkg                                          |
// | Brief   : Shared types and helpers for N-way cache controllers:   |
// |           FSM state encoding, lowest-set-bit encoder, multi-bit   |
// |           detector and associativity legality check.              |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2,
    INSTALL   = 2'd3
  } state_t;

  localparam int c_MAX_WAYS = 8;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [2:0] prio_enc8(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // True when more than one bit of the vector is set.
  function automatic logic multi_bit8(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

  // Only 2-, 4- and 8-way configurations are supported.
  function automatic bit ways_legal(input int w);
    return (w == 2) || (w == 4) || (w == 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_victim_sel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : cache_victim_sel                                        |
// | Brief   : Combinational victim chooser: lowest-index invalid way  |
// |           if one exists, otherwise the pseudo-LRU victim.         |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module cache_victim_sel
  import cache_ctrl_pkg::*;
#(
  parameter  int WAYS  = 4,
  localparam int IDX_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  i_valid_vec,
  input  logic [IDX_W-1:0] i_plru_victim,
  output logic [IDX_W-1:0] o_victim
);

  logic [WAYS-1:0] w_invalid;
  logic [2:0]      w_first_invalid;

  assign w_invalid       = ~i_valid_vec;
  assign w_first_invalid = prio_enc8(8'(w_invalid));

  // Filling an empty way never costs a writeback, so it beats PLRU.
  always_comb begin
    o_victim = i_plru_victim;
    if (|w_invalid) o_victim = w_first_invalid[IDX_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/cache_control_nway.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : cache_control_nway                                      |
// | Brief   : N-way set-associative cache controller FSM with victim  |
// |           capture, sticky multi-hit error and write-wins request  |
// |           priority. Optional macro CACHE_CTRL_PERF_CNT_EN adds    |
// |           hit/miss/writeback counters.                            |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module cache_control_nway
  import cache_ctrl_pkg::*;
#(
  parameter  int WAYS  = 4,
  localparam int IDX_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic [WAYS-1:0]  hit_vec,
  input  logic [WAYS-1:0]  valid_vec,
  input  logic [WAYS-1:0]  dirty_vec,
  input  logic [IDX_W-1:0] plru_victim,
  output logic             plru_update,
  output logic [IDX_W-1:0] plru_way,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic [IDX_W-1:0] way_sel,
  output logic             phys_sel,
  output logic             data_src,
  output logic [WAYS-1:0]  load_data,
  output logic [WAYS-1:0]  load_tag,
  output logic [WAYS-1:0]  load_valid,
  output logic [WAYS-1:0]  load_dirty,
  output logic             dirty_in,
`ifdef CACHE_CTRL_PERF_CNT_EN
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt,
  output logic [31:0]      wb_cnt,
`endif
  output logic             multi_hit_err
);

  if (!ways_legal(WAYS)) begin : g_bad_ways
    $error("cache_control_nway: WAYS must be 2, 4 or 8");
  end

  localparam logic [WAYS-1:0] c_ONE = {{(WAYS-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [IDX_W-1:0] r_victim;
  logic             r_multi_hit_err;

  logic             w_req;
  logic             w_hit;
  logic [2:0]       w_hit_enc;
  logic [IDX_W-1:0] w_hit_idx;
  logic [WAYS-1:0]  w_hit_oh;
  logic [WAYS-1:0]  w_vic_oh;
  logic [IDX_W-1:0] w_new_victim;
  logic             w_new_victim_dirty;

  assign w_req     = mem_read | mem_write;
  assign w_hit     = |hit_vec;
  assign w_hit_enc = prio_enc8(8'(hit_vec));
  assign w_hit_idx = w_hit_enc[IDX_W-1:0];
  assign w_hit_oh  = c_ONE << w_hit_idx;
  assign w_vic_oh  = c_ONE << r_victim;

  cache_victim_sel #(.WAYS(WAYS)) u_victim_sel (
    .i_valid_vec   (valid_vec),
    .i_plru_victim (plru_victim),
    .o_victim      (w_new_victim)
  );

  assign w_new_victim_dirty = valid_vec[w_new_victim] & dirty_vec[w_new_victim];
  assign multi_hit_err      = r_multi_hit_err;

  // FSM, victim capture at miss time and sticky multi-hit detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_victim        <= '0;
      r_multi_hit_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && multi_bit8(8'(hit_vec))) r_multi_hit_err <= 1'b1;
          if (w_req && !w_hit) begin
            r_victim <= w_new_victim;
            r_state  <= w_new_victim_dirty ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: if (pmem_resp) r_state <= FILL;
        FILL:      if (pmem_resp) r_state <= INSTALL;
        INSTALL:   r_state <= IDLE;
        default:   r_state <= IDLE;
      endcase
    end
  end

  // Output decode; a simultaneous read and write is served as a write.
  always_comb begin
    mem_resp    = 1'b0;
    plru_update = 1'b0;
    plru_way    = '0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    way_sel     = '0;
    phys_sel    = 1'b0;
    data_src    = 1'b0;
    load_data   = '0;
    load_tag    = '0;
    load_valid  = '0;
    load_dirty  = '0;
    dirty_in    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req && w_hit) begin
          mem_resp    = 1'b1;
          way_sel     = w_hit_idx;
          plru_update = 1'b1;
          plru_way    = w_hit_idx;
          if (mem_write) begin
            load_data  = w_hit_oh;
            load_dirty = w_hit_oh;
            dirty_in   = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        phys_sel   = 1'b1;
        way_sel    = r_victim;
      end
      FILL: begin
        pmem_read = 1'b1;
      end
      INSTALL: begin
        load_data   = w_vic_oh;
        load_tag    = w_vic_oh;
        load_valid  = w_vic_oh;
        load_dirty  = w_vic_oh;
        data_src    = 1'b1;
        plru_update = 1'b1;
        plru_way    = r_victim;
      end
      default: ;
    endcase
  end

`ifdef CACHE_CTRL_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic [31:0] r_wb_cnt;

  // Free-running wrapping event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (r_state == IDLE && w_req && w_hit)  r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (r_state == IDLE && w_req && !w_hit) r_miss_cnt <= r_miss_cnt + 32'd1;
      if (r_state == WRITEBACK && pmem_resp)  r_wb_cnt   <= r_wb_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
  assign wb_cnt   = r_wb_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_control_nway.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_cache_control_nway                                   |
// | Brief   : Directed self-checking bench for cache_control_nway     |
// |           (WAYS=4); counter checks under CACHE_CTRL_PERF_CNT_EN.  |
// | Rev     : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_cache_control_nway;

  localparam int WAYS  = 4;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mem_read, mem_write, mem_resp;
  logic [WAYS-1:0]  hit_vec, valid_vec, dirty_vec;
  logic [IDX_W-1:0] plru_victim;
  logic             plru_update;
  logic [IDX_W-1:0] plru_way;
  logic             pmem_read, pmem_write, pmem_resp;
  logic [IDX_W-1:0] way_sel;
  logic             phys_sel, data_src;
  logic [WAYS-1:0]  load_data, load_tag, load_valid, load_dirty;
  logic             dirty_in, multi_hit_err;
`ifdef CACHE_CTRL_PERF_CNT_EN
  logic [31:0]      hit_cnt, miss_cnt, wb_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cache_control_nway #(.WAYS(WAYS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_resp      (mem_resp),
    .hit_vec       (hit_vec),
    .valid_vec     (valid_vec),
    .dirty_vec     (dirty_vec),
    .plru_victim   (plru_victim),
    .plru_update   (plru_update),
    .plru_way      (plru_way),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_resp     (pmem_resp),
    .way_sel       (way_sel),
    .phys_sel      (phys_sel),
    .data_src      (data_src),
    .load_data     (load_data),
    .load_tag      (load_tag),
    .load_valid    (load_valid),
    .load_dirty    (load_dirty),
    .dirty_in      (dirty_in),
`ifdef CACHE_CTRL_PERF_CNT_EN
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt),
    .wb_cnt        (wb_cnt),
`endif
    .multi_hit_err (multi_hit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    hit_vec = 4'b0000; valid_vec = 4'b0000; dirty_vec = 4'b0000; plru_victim = 2'd0;
    #1;
    chk("rst_mem_resp",  32'(mem_resp), 32'd0);
    chk("rst_pmem_read", 32'(pmem_read), 32'd0);
    chk("rst_mhe",       32'(multi_hit_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read hit in way 2
    step();
    mem_read = 1'b1; hit_vec = 4'b0100; valid_vec = 4'b1111;
    #1;
    chk("rd_hit_resp",      32'(mem_resp), 32'd1);
    chk("rd_hit_plru_upd",  32'(plru_update), 32'd1);
    chk("rd_hit_plru_way",  32'(plru_way), 32'd2);
    chk("rd_hit_way_sel",   32'(way_sel), 32'd2);
    chk("rd_hit_pmem",      32'({pmem_read, pmem_write}), 32'd0);
    chk("rd_hit_load_data", 32'(load_data), 32'd0);

    // Write hit in way 0 (read also high: write wins)
    step();
    mem_write = 1'b1; hit_vec = 4'b0001;
    #1;
    chk("wr_hit_load_data",  32'(load_data), 32'b0001);
    chk("wr_hit_load_dirty", 32'(load_dirty), 32'b0001);
    chk("wr_hit_dirty_in",   32'(dirty_in), 32'd1);
    chk("wr_hit_data_src",   32'(data_src), 32'd0);
    chk("wr_hit_resp",       32'(mem_resp), 32'd1);

    // Read miss, way 2 invalid beats PLRU way 3; request dropped during fill
    step();
    mem_write = 1'b0; hit_vec = 4'b0000; valid_vec = 4'b1011; dirty_vec = 4'b0000;
    plru_victim = 2'd3;
    #1;
    chk("miss_detect_resp", 32'(mem_resp), 32'd0);
    chk("miss_detect_pmem", 32'(pmem_read), 32'd0);
    step();
    mem_read = 1'b0;
    #1;
    chk("fill_pmem_read", 32'(pmem_read), 32'd1);
    chk("fill_phys_sel",  32'(phys_sel), 32'd0);
    chk("fill_pmem_wr",   32'(pmem_write), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fill_hold", 32'(pmem_read), 32'd1);
    end
    step();
    pmem_resp = 1'b1;
    #1;
    chk("fill_last", 32'(pmem_read), 32'd1);
    step();
    pmem_resp = 1'b0;
    #1;
    chk("inst_load_tag",   32'(load_tag), 32'b0100);
    chk("inst_load_data",  32'(load_data), 32'b0100);
    chk("inst_load_valid", 32'(load_valid), 32'b0100);
    chk("inst_load_dirty", 32'(load_dirty), 32'b0100);
    chk("inst_data_src",   32'(data_src), 32'd1);
    chk("inst_dirty_in",   32'(dirty_in), 32'd0);
    chk("inst_plru_way",   32'({plru_update, plru_way}), 32'b110);
    chk("inst_no_resp",    32'(mem_resp), 32'd0);
    step();
    chk("post_inst_idle", 32'({mem_resp, pmem_read, load_tag}), 32'd0);
    mem_read = 1'b1; hit_vec = 4'b0100; valid_vec = 4'b1111;
    #1;
    chk("retry_hit_resp", 32'(mem_resp), 32'd1);
    chk("retry_way_sel",  32'(way_sel), 32'd2);

    // Read miss with dirty PLRU victim way 1 -> writeback first
    step();
    hit_vec = 4'b0000; valid_vec = 4'b1111; dirty_vec = 4'b0010; plru_victim = 2'd1;
    step();
    chk("wb_pmem_write", 32'(pmem_write), 32'd1);
    chk("wb_phys_sel",   32'(phys_sel), 32'd1);
    chk("wb_way_sel",    32'(way_sel), 32'd1);
    chk("wb_no_read",    32'(pmem_read), 32'd0);
    step();
    chk("wb_hold", 32'(pmem_write), 32'd1);
    pmem_resp = 1'b1;
    step();
    chk("wb2fill_read",  32'(pmem_read), 32'd1);
    chk("wb2fill_write", 32'(pmem_write), 32'd0);
    step();
    pmem_resp = 1'b0;
    #1;
    chk("wb_inst_tag",  32'(load_tag), 32'b0010);
    chk("wb_inst_plru", 32'(plru_way), 32'd1);
    step();
    hit_vec = 4'b0010;
    #1;
    chk("wb_retry_resp", 32'(mem_resp), 32'd1);

    // pmem_resp in IDLE is ignored
    step();
    mem_read = 1'b0; hit_vec = 4'b0000; pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    #1;
    chk("idle_resp_ignored", 32'({pmem_read, pmem_write, load_tag}), 32'd0);

    // Reset mid-fill: way 3 invalid -> FILL, then async reset
    mem_read = 1'b1; valid_vec = 4'b0111; dirty_vec = 4'b0000;
    step();
    chk("pre_rst_fill", 32'(pmem_read), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_pmem", 32'(pmem_read), 32'd0);
    mem_read = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_stale_inst", 32'({load_tag, load_data, pmem_read}), 32'd0);
    end
    chk("mhe_clear_after_rst", 32'(multi_hit_err), 32'd0);

    // Multi-hit: ways 1 and 2 -> lowest way 1, sticky error
    mem_read = 1'b1; hit_vec = 4'b0110; valid_vec = 4'b1111;
    #1;
    chk("mh_way_sel",  32'(way_sel), 32'd1);
    chk("mh_plru_way", 32'(plru_way), 32'd1);
    chk("mh_resp",     32'(mem_resp), 32'd1);
    step();
    mem_read = 1'b0; hit_vec = 4'b0000;
    #1;
    chk("mh_err_set", 32'(multi_hit_err), 32'd1);
    step();
    step();
    chk("mh_err_sticky", 32'(multi_hit_err), 32'd1);
`ifdef CACHE_CTRL_PERF_CNT_EN
    chk("cnt_hit",  hit_cnt, 32'd1);
    chk("cnt_miss", miss_cnt, 32'd0);
    chk("cnt_wb",   wb_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
